mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_store.sv | 29 ++
 rtl/mem_responder.sv | 92 +++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

  localparam int          LINE_W  = 64;
  localparam int          STRB_W  = LINE_W / 8;
  localparam logic [3:0]  RD_STRB = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_store.sv
// Backing store: 2^AW lines of 64 bits, byte-enabled write, asynchronous read.
module mem_store
  import mem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     widx,
  input  logic [LINE_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [AW-1:0]     ridx,
  output logic [LINE_W-1:0] rdata
);

  logic [STRB_W-1:0][7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[widx][b] <= wdata[8*b +: 8];
      end
    end
  end

  // Read is combinational, so a same-edge write is seen only after the edge.
  assign rdata = mem[ridx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line read responder over a byte-writable backing store.
// Optional sticky request-error output enabled by MEM_RESPONDER_ERR_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int AW      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [63:0]       rd_addr,
  input  logic [3:0]        rd_wstrb,
  output logic              rd_ready,
  output logic              ret_valid,
  output logic [LINE_W-1:0] ret_data,
  input  logic              wr_en,
  input  logic [63:0]       wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb
`ifdef MEM_RESPONDER_ERR_EN
  ,
  output logic              err
`endif
);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [AW-1:0]     req_idx;
  logic [LINE_W-1:0] mem_rdata;
  logic              accept, capture;

  assign rd_ready  = (state == ST_IDLE);
  assign ret_valid = (state == ST_RESP);
  assign accept    = rd_ready && rd_req;
  assign capture   = (state == ST_WAIT) && (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      req_idx  <= '0;
      ret_data <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept)  req_idx  <= rd_addr[AW+2:3];
      if (capture) ret_data <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: if (rd_req) begin
        state_nxt = ST_WAIT;
        cnt_nxt   = 4'(LATENCY - 1);
      end
      ST_WAIT: if (cnt != '0) cnt_nxt = cnt - 4'd1;
               else           state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  mem_store #(.AW(AW)) u_store (
    .clk   (clk),
    .we    (wr_en && rst),
    .widx  (wr_addr[AW+2:3]),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .ridx  (req_idx),
    .rdata (mem_rdata)
  );

`ifdef MEM_RESPONDER_ERR_EN
  logic bad_req;
  assign bad_req = (rd_wstrb != RD_STRB) || (rd_addr[63:AW+3] != '0);

  always_ff @(posedge clk) begin
    if (!rst)                   err <= 1'b0;
    else if (accept && bad_req) err <= 1'b1;
  end
`endif

  // Address bits outside the line index never affect the store.
  logic unused_bits;
  assign unused_bits = ^{rd_wstrb, rd_addr[63:AW+3], rd_addr[2:0],
                         wr_addr[63:AW+3], wr_addr[2:0]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed + randomized bench for mem_responder against a line-array reference model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 2;
  localparam int AW  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [63:0] rd_addr;
  logic [3:0]  rd_wstrb;
  logic        rd_ready;
  logic        ret_valid;
  logic [63:0] ret_data;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
`ifdef MEM_RESPONDER_ERR_EN
  logic        err;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] mdl [16];
  logic        err_m = 1'b0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(LAT), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_wstrb  (rd_wstrb),
    .rd_ready  (rd_ready),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb)
`ifdef MEM_RESPONDER_ERR_EN
    ,
    .err       (err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_addr(input int idx, input logic [63:0] hi);
    return (hi << (AW + 3)) | (64'(idx) << 3) | 64'($urandom_range(0, 7));
  endfunction

  // Drives one write for the current cycle and applies it to the model.
  task automatic drive_wr(input int idx, input logic [63:0] d, input logic [7:0] s);
    wr_en   = 1'b1;
    wr_addr = mk_addr(idx, 64'($urandom));
    wr_data = d;
    wr_strb = s;
    for (int b = 0; b < 8; b++)
      if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic write1(input int idx, input logic [63:0] d, input logic [7:0] s);
    drive_wr(idx, d, s);
    tick;
    wr_en = 1'b0;
  endtask

  task automatic do_reset;
    rst    = 1'b0;
    rd_req = 1'b0;
    wr_en  = 1'b0;
    err_m  = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_ret_data", ret_data, 0);
    chk("rst_rd_ready", rd_ready, 1);
`ifdef MEM_RESPONDER_ERR_EN
    chk("rst_err", err, 0);
`endif
  endtask

  // mode 0: no writes; 1: random writes each cycle; 2: write cdata to idx in the capture cycle.
  // Data is captured at the edge closing cycle LAT after accept, so a write
  // in that same cycle is not yet visible.
  task automatic do_read(input int idx, input logic [63:0] hi, input logic [3:0] strb,
                         input bit hold, input int mode, input logic [63:0] cdata);
    logic [63:0] exp;
    exp      = '0;
    rd_req   = 1'b1;
    rd_addr  = mk_addr(idx, hi);
    rd_wstrb = strb;
    chk("rd_ready_idle", rd_ready, 1);
    for (int k = 0; k <= LAT + 1; k++) begin
      wr_en = 1'b0;
      if (k > 0) begin
        chk("ret_valid", ret_valid, 64'(k == LAT + 1));
        chk("rd_ready_busy", rd_ready, 0);
`ifdef MEM_RESPONDER_ERR_EN
        chk("err", err, err_m);
`endif
      end
      if (k == LAT) exp = mdl[idx];
      if (mode == 1 && $urandom_range(0, 1) == 1)
        drive_wr($urandom_range(0, 15), {$urandom, $urandom}, 8'($urandom));
      if (mode == 2 && k == LAT) drive_wr(idx, cdata, 8'hFF);
      if (k == LAT + 1) chk("ret_data", ret_data, exp);
      if (k == 0 && (strb != 4'hF || hi != 0)) err_m = 1'b1;
      if (k > 0) rd_req = hold;
      tick;
    end
    wr_en  = 1'b0;
    rd_req = 1'b0;
    chk("ret_valid_done", ret_valid, 0);
    chk("rd_ready_done", rd_ready, 1);
    chk("ret_data_hold", ret_data, exp);
  endtask

  initial begin
    rst      = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    rd_wstrb = 4'hF;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_strb  = '0;
    do_reset;

    for (int i = 0; i < 16; i++) write1(i, {$urandom, $urandom}, 8'hFF);

    // Basic read of a preloaded line.
    write1(5, 64'h1122334455667788, 8'hFF);
    do_read(5, 0, 4'hF, 1'b0, 0, 0);
    chk("basic_data", ret_data, 64'h1122334455667788);

    // Request held through WAIT/RESP yields one pulse.
    do_read(5, 0, 4'hF, 1'b1, 0, 0);

    // Partial byte write merges into existing line.
    write1(5, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
    write1(5, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    do_read(5, 0, 4'hF, 1'b0, 0, 0);
    chk("strb_merge", ret_data, 64'hFFFFFFFF_BBBBBBBB);

    // Same-edge write vs capture: old data first, new data next time.
    write1(7, 64'h0707070707070707, 8'hFF);
    do_read(7, 0, 4'hF, 1'b0, 2, 64'hDEADBEEF_CAFEF00D);
    chk("rbw_old", ret_data, 64'h0707070707070707);
    do_read(7, 0, 4'hF, 1'b0, 0, 0);
    chk("rbw_new", ret_data, 64'hDEADBEEF_CAFEF00D);

    // Reset mid-WAIT aborts the read; writes during reset are dropped.
    write1(9, 64'h0123456789ABCDEF, 8'hFF);
    rd_req  = 1'b1;
    rd_addr = mk_addr(9, 0);
    tick;
    rd_req = 1'b0;
    tick;
    rst     = 1'b0;
    wr_en   = 1'b1;
    wr_addr = mk_addr(9, 0);
    wr_data = 64'h5555555555555555;
    wr_strb = 8'hFF;
    err_m   = 1'b0;
    tick;
    rst   = 1'b1;
    wr_en = 1'b0;
    chk("abort_rd_ready", rd_ready, 1);
    chk("abort_ret_data", ret_data, 0);
    for (int i = 0; i < LAT + 2; i++) begin
      chk("abort_no_valid", ret_valid, 0);
      tick;
    end
    do_read(9, 0, 4'hF, 1'b0, 0, 0);
    chk("mem_intact", ret_data, 64'h0123456789ABCDEF);

    // Non-standard strobe and high address bits: read unaffected, err sticky.
    do_read(3, 0, 4'b0011, 1'b0, 0, 0);
`ifdef MEM_RESPONDER_ERR_EN
    chk("err_strb", err, 1);
`endif
    do_read(4, 0, 4'hF, 1'b0, 0, 0);
`ifdef MEM_RESPONDER_ERR_EN
    chk("err_sticky", err, 1);
`endif
    do_reset;
    do_read(6, 64'h1, 4'hF, 1'b0, 0, 0);
`ifdef MEM_RESPONDER_ERR_EN
    chk("err_hiaddr", err, 1);
`endif
    do_reset;

    // Random reads with interleaved random writes.
    for (int n = 0; n < 40; n++)
      do_read($urandom_range(0, 15), 0, 4'hF, 1'($urandom_range(0, 1)), 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
